// File: rtl/pipe_stage_buf.sv
// pipe_stage_buf: DEPTH-entry first-word-fall-through pipeline buffer with freeze/flush.
// Define PIPE_STAGE_BUF_STALL_CNT_EN to enable the saturating stall counter.
module pipe_stage_buf #(
  parameter int DATA_W = 32,
  parameter int DEST_W = 4,
  parameter int DEPTH  = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic                       in_wb_en,
  input  logic                       in_mem_r_en,
  input  logic [DEST_W-1:0]          in_dest,
  input  logic [DATA_W-1:0]          in_alu_res,
  input  logic [DATA_W-1:0]          in_mem_data,
  input  logic                       freeze,
  input  logic                       flush,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic                       out_wb_en,
  output logic                       out_mem_r_en,
  output logic [DEST_W-1:0]          out_dest,
  output logic [DATA_W-1:0]          out_alu_res,
  output logic [DATA_W-1:0]          out_mem_data,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic [15:0]                stall_cnt
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam int EW = 2 + DEST_W + 2*DATA_W;
  logic [EW-1:0] mem [DEPTH];
  logic [EW-1:0] head, last;
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic push, pop;
  function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
    return p == PW'(DEPTH-1) ? '0 : p + 1'b1;
  endfunction
  assign in_ready = (count != CW'(DEPTH)) & ~freeze & ~flush;
  assign out_valid = count != '0;
  assign push = in_valid & in_ready;
  assign pop = out_valid & out_ready & ~freeze;
  // An empty buffer keeps showing the last head's data; control bits are gated.
  assign head = out_valid ? mem[rd_ptr] : last;
  assign out_wb_en = head[EW-1] & out_valid;
  assign out_mem_r_en = head[EW-2] & out_valid;
  assign out_dest = head[2*DATA_W +: DEST_W];
  assign out_alu_res = head[DATA_W +: DATA_W];
  assign out_mem_data = head[DATA_W-1:0];
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      last <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (out_valid) last <= mem[rd_ptr];
      if (flush) begin
        count <= '0;
        rd_ptr <= '0;
        wr_ptr <= '0;
      end else begin
        if (push) begin
          mem[wr_ptr] <= {in_wb_en, in_mem_r_en, in_dest, in_alu_res, in_mem_data};
          wr_ptr <= inc(wr_ptr);
        end
        if (pop) rd_ptr <= inc(rd_ptr);
        count <= (push & ~pop) ? count + 1'b1 : (~push & pop) ? count - 1'b1 : count;
      end
    end
  end
`ifdef PIPE_STAGE_BUF_STALL_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) stall_cnt <= '0;
    else if (in_valid & ~in_ready & ~&stall_cnt) stall_cnt <= stall_cnt + 1'b1;
  end
`else
  assign stall_cnt = '0;
`endif
endmodule

// File: tb/tb_pipe_stage_buf.sv
// tb_pipe_stage_buf: directed checks on a DEPTH=2 instance plus a wrap-around stream on DEPTH=4.
module tb_pipe_stage_buf;
`ifdef PIPE_STAGE_BUF_STALL_CNT_EN
  localparam int STALL_EXP = 5;
`else
  localparam int STALL_EXP = 0;
`endif
  logic clk = 0, rst = 1;
  logic iv = 0, ir, wb = 0, mr = 0, frz = 0, fl = 0, ov, ordy = 0, owb, omr;
  logic [3:0] dst = 0, odst;
  logic [31:0] alu = 0, md = 0, oalu, omd;
  logic [1:0] cnt;
  logic [15:0] stl;
  logic iv4 = 0, ir4, ov4, ordy4 = 0, owb4, omr4, zero4 = 0;
  logic [3:0] dst4 = 0, odst4;
  logic [31:0] alu4 = 0, oalu4, omd4;
  logic [2:0] cnt4;
  logic [15:0] stl4;
  int n_cmp = 0, n_err = 0;
  always #5 clk = ~clk;
  pipe_stage_buf #(.DATA_W(32), .DEST_W(4), .DEPTH(2)) u2 (
    .clk(clk), .rst(rst), .in_valid(iv), .in_ready(ir), .in_wb_en(wb), .in_mem_r_en(mr),
    .in_dest(dst), .in_alu_res(alu), .in_mem_data(md), .freeze(frz), .flush(fl),
    .out_valid(ov), .out_ready(ordy), .out_wb_en(owb), .out_mem_r_en(omr), .out_dest(odst),
    .out_alu_res(oalu), .out_mem_data(omd), .count(cnt), .stall_cnt(stl));
  pipe_stage_buf #(.DATA_W(32), .DEST_W(4), .DEPTH(4)) u4 (
    .clk(clk), .rst(rst), .in_valid(iv4), .in_ready(ir4), .in_wb_en(1'b1), .in_mem_r_en(1'b0),
    .in_dest(dst4), .in_alu_res(alu4), .in_mem_data(alu4), .freeze(zero4), .flush(zero4),
    .out_valid(ov4), .out_ready(ordy4), .out_wb_en(owb4), .out_mem_r_en(omr4), .out_dest(odst4),
    .out_alu_res(oalu4), .out_mem_data(omd4), .count(cnt4), .stall_cnt(stl4));
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  initial begin
    int sent, recv;
    #2;
    chk("rst_count", cnt, 0);
    chk("rst_out_valid", ov, 0);
    chk("rst_in_ready", ir, 1);
    chk("rst_alu", oalu, 0);
    chk("rst_dest", odst, 0);
    @(negedge clk) rst = 0;
    iv = 1; dst = 4'h3; alu = 32'hAA; wb = 1; md = 32'h11;
    step();
    iv = 0;
    chk("one_valid", ov, 1);
    chk("one_dest", odst, 3);
    chk("one_alu", oalu, 32'hAA);
    chk("one_count", cnt, 1);
    chk("one_wb", owb, 1);
    frz = 1; iv = 1; dst = 4'h5; alu = 32'hBB; ordy = 1;
    #1 chk("frz_in_ready", ir, 0);
    repeat (3) step();
    chk("frz_count", cnt, 1);
    chk("frz_alu", oalu, 32'hAA);
    chk("frz_dest", odst, 3);
    frz = 0; iv = 0;
    step();
    ordy = 0;
    chk("drain_valid", ov, 0);
    chk("drain_wb_gated", owb, 0);
    chk("drain_data_hold", oalu, 32'hAA);
    iv = 1; alu = 1; step();
    alu = 2; step();
    alu = 3;
    #1 chk("full_in_ready", ir, 0);
    step();
    chk("full_count", cnt, 2);
    chk("ord_head1", oalu, 1);
    ordy = 1;
    #1 chk("full_pop_in_ready", ir, 0);
    step();
    chk("ord_head2", oalu, 2);
    chk("ord_count_a", cnt, 1);
    step();
    iv = 0;
    chk("ord_head3", oalu, 3);
    chk("ord_count_b", cnt, 1);
    step();
    ordy = 0;
    chk("ord_empty", cnt, 0);
    iv = 1; alu = 32'h10; step();
    alu = 32'h20; step();
    chk("fl_pre_count", cnt, 2);
    fl = 1; alu = 32'h30;
    #1 chk("fl_in_ready", ir, 0);
    step();
    fl = 0; iv = 0;
    chk("fl_count", cnt, 0);
    chk("fl_valid", ov, 0);
    chk("fl_wb", owb, 0);
    step();
    chk("fl_dropped", cnt, 0);
    iv = 1; alu = 32'h40; step();
    iv = 0;
    chk("fl_ptr_head", oalu, 32'h40);
    chk("fl_ptr_count", cnt, 1);
    @(negedge clk) rst = 1;
    @(negedge clk) rst = 0;
    iv = 1; alu = 32'h50; step();
    alu = 32'h60; step();
    repeat (5) step();
    chk("stall_cnt", stl, STALL_EXP);
    chk("stall_full", cnt, 2);
    #2 rst = 1;
    #1;
    chk("arst_count", cnt, 0);
    chk("arst_stall", stl, 0);
    chk("arst_valid", ov, 0);
    alu = 32'h77;
    @(negedge clk) rst = 0;
    step();
    iv = 0;
    chk("post_rst_count", cnt, 1);
    chk("post_rst_head", oalu, 32'h77);
    sent = 0; recv = 0;
    for (int c = 0; c < 300 && recv < 10; c++) begin
      iv4 = sent < 10;
      alu4 = 32'h1000 + 32'(sent * 3);
      dst4 = 4'(sent);
      ordy4 = 1'($urandom_range(0, 1));
      #1;
      if (ov4 && ordy4) chk("stream_data", {odst4, oalu4}, {4'(recv), 32'h1000 + 32'(recv * 3)});
      if (iv4 && ir4) sent++;
      if (ov4 && ordy4) recv++;
      step();
    end
    iv4 = 0; ordy4 = 0;
    chk("stream_done", 64'(recv), 10);
    chk("stream_count", cnt4, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
